// File: rtl/vpu_load_seq_if.sv
// Tile stream channel into the load sequencer: valid/ready beats carrying A columns then W rows.
interface vpu_load_seq_if #(
    parameter int BUS_WIDTH = 32
) ();
    logic                 s_valid;
    logic                 s_ready;
    logic [BUS_WIDTH-1:0] s_data;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/vpu_load_seq.sv
// Tile load sequencer: buffers one tile, replays it as aligned load bursts, then runs the deload window.
// Optional fill-stall statistics are enabled by defining VPU_LDSEQ_STATS_EN.
module vpu_load_seq #(
    parameter int N          = 4,
    parameter int BUS_WIDTH  = 32,
    parameter int LOAD_LAT   = 2,
    parameter int DELOAD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    vpu_load_seq_if.slave        s,
    output logic                 load_a,
    output logic                 load_w,
    output logic [BUS_WIDTH-1:0] a,
    output logic [BUS_WIDTH-1:0] w,
    output logic                 deload,
    output logic [$clog2(N)-1:0] count_deload_a,
    output logic [$clog2(N)-1:0] count_deload_w,
    output logic [N-1:0]         johnson_count,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          stall_cycles
);
    localparam int IW = $clog2(N);
    localparam int BW = $clog2(2 * N);
    localparam int DW = $clog2(LOAD_LAT + 2);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_BURST  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DELOAD = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    function automatic logic [N-1:0] johnson_next(input logic [N-1:0] cur);
        return {cur[N-2:0], ~cur[N-1]};
    endfunction

    state_t               state_r;
    logic [BW-1:0]        beat_cnt_r;
    logic [IW-1:0]        burst_cnt_r;
    logic [DW-1:0]        drain_cnt_r;
    logic [IW-1:0]        idx_r;
    logic                 s_ready_r;
    logic                 load_r;
    logic                 deload_r;
    logic [N-1:0]         johnson_r;
    logic                 busy_r;
    logic                 accept_s;

    logic [BUS_WIDTH-1:0] tile_a_r [N];
    logic [BUS_WIDTH-1:0] tile_w_r [N];

    logic [BUS_WIDTH-1:0] a_pipe_r    [LOAD_LAT];
    logic [BUS_WIDTH-1:0] w_pipe_r    [LOAD_LAT];
    logic [IW-1:0]        idx_pipe_r  [DELOAD_LAT];
    logic                 last_pipe_r [DELOAD_LAT];

    assign accept_s  = s_ready_r & s.s_valid;
    assign s.s_ready = s_ready_r;

    // Sequencing FSM with its registered strobes, counters and Johnson phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            beat_cnt_r  <= '0;
            burst_cnt_r <= '0;
            drain_cnt_r <= '0;
            idx_r       <= '0;
            s_ready_r   <= 1'b0;
            load_r      <= 1'b0;
            deload_r    <= 1'b0;
            johnson_r   <= '0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_FILL;
                        s_ready_r  <= 1'b1;
                        busy_r     <= 1'b1;
                        beat_cnt_r <= '0;
                    end
                end
                ST_FILL: begin
                    if (accept_s) begin
                        beat_cnt_r <= beat_cnt_r + BW'(1);
                        if (beat_cnt_r == BW'(2 * N - 1)) begin
                            state_r     <= ST_BURST;
                            s_ready_r   <= 1'b0;
                            load_r      <= 1'b1;
                            burst_cnt_r <= '0;
                        end
                    end
                end
                ST_BURST: begin
                    // The run must stay unbroken: the loader restarts its write pointer on a strobe gap
                    burst_cnt_r <= burst_cnt_r + IW'(1);
                    if (burst_cnt_r == IW'(N - 1)) begin
                        state_r     <= ST_DRAIN;
                        load_r      <= 1'b0;
                        drain_cnt_r <= '0;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt_r <= drain_cnt_r + DW'(1);
                    if (drain_cnt_r == DW'(LOAD_LAT)) begin
                        state_r   <= ST_DELOAD;
                        deload_r  <= 1'b1;
                        idx_r     <= '0;
                        johnson_r <= johnson_next('0);
                    end
                end
                ST_DELOAD: begin
                    idx_r     <= idx_r + IW'(1);
                    johnson_r <= johnson_next(johnson_r);
                    if (idx_r == IW'(N - 1)) begin
                        state_r   <= ST_DONE;
                        deload_r  <= 1'b0;
                        johnson_r <= '0;
                    end
                end
                ST_DONE: begin
                    // Stay until the delayed last index (and done) reaches the output
                    if (last_pipe_r[DELOAD_LAT-1]) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    s_ready_r <= 1'b0;
                    load_r    <= 1'b0;
                    deload_r  <= 1'b0;
                    johnson_r <= '0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    // Tile buffer write; contents need no reset since every slot is rewritten before it is read
    always_ff @(posedge clk) begin
        if (accept_s) begin
            if (beat_cnt_r[BW-1]) begin
                tile_w_r[beat_cnt_r[BW-2:0]] <= s.s_data;
            end else begin
                tile_a_r[beat_cnt_r[BW-2:0]] <= s.s_data;
            end
        end
    end

    // Load data pipeline aligning a/w with the loader's sample point; idle slots carry zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LOAD_LAT; i++) begin
                a_pipe_r[i] <= '0;
                w_pipe_r[i] <= '0;
            end
        end else begin
            a_pipe_r[0] <= load_r ? tile_a_r[burst_cnt_r] : '0;
            w_pipe_r[0] <= load_r ? tile_w_r[burst_cnt_r] : '0;
            for (int i = 1; i < LOAD_LAT; i++) begin
                a_pipe_r[i] <= a_pipe_r[i-1];
                w_pipe_r[i] <= w_pipe_r[i-1];
            end
        end
    end

    // Deload index pipeline; the last-index flag rides along and becomes done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DELOAD_LAT; i++) begin
                idx_pipe_r[i]  <= '0;
                last_pipe_r[i] <= 1'b0;
            end
        end else begin
            idx_pipe_r[0]  <= deload_r ? idx_r : '0;
            last_pipe_r[0] <= deload_r && (idx_r == IW'(N - 1));
            for (int i = 1; i < DELOAD_LAT; i++) begin
                idx_pipe_r[i]  <= idx_pipe_r[i-1];
                last_pipe_r[i] <= last_pipe_r[i-1];
            end
        end
    end

`ifdef VPU_LDSEQ_STATS_EN
    logic [15:0] stall_r;

    // Fill-stall counter: cleared by an accepted start, saturating, held after the tile completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_r <= '0;
        end else if (state_r == ST_IDLE && start) begin
            stall_r <= '0;
        end else if (state_r == ST_FILL && !s.s_valid && stall_r != 16'hFFFF) begin
            stall_r <= stall_r + 16'd1;
        end
    end

    assign stall_cycles = stall_r;
`else
    assign stall_cycles = 16'd0;
`endif

    assign load_a         = load_r;
    assign load_w         = load_r;
    assign a              = a_pipe_r[LOAD_LAT-1];
    assign w              = w_pipe_r[LOAD_LAT-1];
    assign deload         = deload_r;
    assign count_deload_a = idx_pipe_r[DELOAD_LAT-1];
    assign count_deload_w = idx_pipe_r[DELOAD_LAT-1];
    assign johnson_count  = johnson_r;
    assign busy           = busy_r;
    assign done           = last_pipe_r[DELOAD_LAT-1];

endmodule

// File: tb/tb_vpu_load_seq.sv
// Bench for vpu_load_seq: directed vector table, hand-written corner sequences and randomized tiles
// checked cycle by cycle against a timeline model derived from the sequencing rules.
module tb_vpu_load_seq;
    localparam int N  = 4;
    localparam int BW = 32;
    localparam int LL = 2;
    localparam int DL = 1;
    localparam int IW = 2;
    localparam int RL = 64;

    typedef logic [BW-1:0] beats_t [2*N];
    typedef bit pat_t [RL];
    typedef struct {
        int gap_at;
        int gap_len;
        int exp_done;
        int exp_stall;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          load_a, load_w, deload, done, busy;
    logic [BW-1:0] a, w;
    logic [IW-1:0] cda, cdw;
    logic [N-1:0]  john;
    logic [15:0]   stall;

    int tests = 0;
    int fails = 0;
    int prev_stall = 0;
    int seen_done = -1;

    vpu_load_seq_if #(.BUS_WIDTH(BW)) sif ();

    vpu_load_seq #(.N(N), .BUS_WIDTH(BW), .LOAD_LAT(LL), .DELOAD_LAT(DL)) dut (
        .clk(clk), .reset(reset), .start(start), .s(sif),
        .load_a(load_a), .load_w(load_w), .a(a), .w(w), .deload(deload),
        .count_deload_a(cda), .count_deload_w(cdw), .johnson_count(john),
        .busy(busy), .done(done), .stall_cycles(stall)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int r, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s rel=%0d got=0x%0h expected=0x%0h", nm, r, act, exp);
        end
    endtask

    task automatic chk_all(input int r, input bit e_load, input logic [BW-1:0] e_a, input logic [BW-1:0] e_w,
                           input bit e_rdy, input bit e_del, input logic [N-1:0] e_j, input logic [IW-1:0] e_i,
                           input bit e_done, input bit e_busy, input logic [15:0] e_stall);
        chk("load_a", r, 64'(load_a), 64'(e_load));
        chk("load_w", r, 64'(load_w), 64'(e_load));
        chk("a", r, 64'(a), 64'(e_a));
        chk("w", r, 64'(w), 64'(e_w));
        chk("s_ready", r, 64'(sif.s_ready), 64'(e_rdy));
        chk("deload", r, 64'(deload), 64'(e_del));
        chk("johnson", r, 64'(john), 64'(e_j));
        chk("idx_a", r, 64'(cda), 64'(e_i));
        chk("idx_w", r, 64'(cdw), 64'(e_i));
        chk("done", r, 64'(done), 64'(e_done));
        chk("busy", r, 64'(busy), 64'(e_busy));
        chk("stall_cycles", r, 64'(stall), 64'(e_stall));
    endtask

    // Valid pattern: continuous beats except a gap of gap_len cycles once gap_at beats are in
    task automatic mk_pat(input int gap_at, input int gap_len, output pat_t vp);
        int cnt;
        int g;
        cnt = 0;
        g = gap_len;
        vp[0] = 1'b0;
        for (int r = 1; r < RL; r++) begin
            if (cnt == gap_at && g > 0) begin
                vp[r] = 1'b0;
                g--;
            end else begin
                vp[r] = 1'b1;
                cnt++;
            end
        end
    endtask

    // Drives one tile starting now (just after a rising edge) and checks every cycle until done
    task automatic run_tile(input beats_t beats, input pat_t vpat, input pat_t spat, input int abort_at);
        int last, acc, b0, d0, e0, stl;
        logic [BW-1:0] sdat [RL];
        last = -1;
        acc = 0;
        stl = 0;
        seen_done = -1;
        for (int r = 0; r < RL; r++) sdat[r] = 32'hBAD0_0000 | BW'(r);
        for (int r = 1; r < RL && last < 0; r++) begin
            if (vpat[r]) begin
                sdat[r] = beats[acc];
                acc++;
                if (acc == 2 * N) last = r;
            end else begin
                stl++;
            end
        end
        if (last < 0 || last > RL - 20) begin
            tests++;
            fails++;
            $display("FAIL model_window last=%0d", last);
            return;
        end
        b0 = last + 1;
        d0 = b0 + N + LL + 1;
        e0 = d0 + N - 1 + DL;
        for (int r = 0; r <= e0; r++) begin
            logic [BW-1:0] ea, ew;
            logic [N-1:0]  ej;
            logic [IW-1:0] ei;
            int            es;
            start = (r == 0) || spat[r];
            sif.s_valid = vpat[r];
            sif.s_data = sdat[r];
            @(negedge clk);
            ea = '0;
            ew = '0;
            if (r >= b0 + LL && r < b0 + LL + N) begin
                ea = beats[r - b0 - LL];
                ew = beats[N + r - b0 - LL];
            end
            ej = (r >= d0 && r < d0 + N) ? N'((1 << (r - d0 + 1)) - 1) : '0;
            ei = (r >= d0 + DL && r < d0 + DL + N) ? IW'(r - d0 - DL) : '0;
`ifdef VPU_LDSEQ_STATS_EN
            if (r == 0) begin
                es = prev_stall;
            end else begin
                es = 0;
                for (int q = 1; q < r && q <= last; q++) if (!vpat[q]) es++;
            end
`else
            es = 0;
`endif
            if (done === 1'b1 && seen_done < 0) seen_done = r;
            chk_all(r, r >= b0 && r < b0 + N, ea, ew, r >= 1 && r <= last, r >= d0 && r < d0 + N,
                    ej, ei, r == e0, r >= 1 && r <= e0, 16'(es));
            if (r == abort_at) begin
                start = 1'b0;
                #1 reset = 1'b0;
                #1 chk_all(r, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 16'd0);
                prev_stall = 0;
                return;
            end
            @(posedge clk);
            #1;
        end
`ifdef VPU_LDSEQ_STATS_EN
        prev_stall = stl;
`else
        prev_stall = 0;
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            sif.s_valid = 1'($urandom_range(1));
            sif.s_data = $urandom;
            @(negedge clk);
            chk_all(-1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 16'(prev_stall));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vec_t   vt [4];
        beats_t bt;
        pat_t   vp;
        pat_t   sp;
        pat_t   sp0;
        int     cnt;
        int     budget;

        reset = 1'b0;
        start = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_data = '0;
        for (int r = 0; r < RL; r++) sp0[r] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all(-2, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 16'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        vt[0] = '{-1, 0, 20, 0};
        vt[1] = '{3, 3, 23, 3};
        vt[2] = '{0, 2, 22, 2};
        vt[3] = '{7, 5, 25, 5};
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 2 * N; b++) bt[b] = (i == 0) ? BW'(b + 1) : $urandom;
            mk_pat(vt[i].gap_at, vt[i].gap_len, vp);
            run_tile(bt, vp, sp0, -1);
            chk("done_cycle", i, 64'(seen_done), 64'(vt[i].exp_done));
`ifdef VPU_LDSEQ_STATS_EN
            chk("stall_total", i, 64'(stall), 64'(vt[i].exp_stall));
`else
            chk("stall_total", i, 64'(stall), 64'(0));
`endif
            idle(2);
        end

        // start pulses during FILL, DELOAD and DONE are ignored, then two back-to-back tiles
        for (int b = 0; b < 2 * N; b++) bt[b] = $urandom;
        mk_pat(-1, 0, vp);
        sp = sp0;
        sp[3] = 1'b1;
        sp[17] = 1'b1;
        sp[20] = 1'b1;
        run_tile(bt, vp, sp, -1);
        chk("busy_start_done", 0, 64'(seen_done), 64'(20));
        for (int t = 0; t < 2; t++) begin
            for (int b = 0; b < 2 * N; b++) bt[b] = $urandom;
            run_tile(bt, vp, sp0, -1);
            chk("b2b_done", t, 64'(seen_done), 64'(20));
        end
        idle(1);

        // reset in the middle of a burst, then a fresh tile
        for (int b = 0; b < 2 * N; b++) bt[b] = $urandom;
        run_tile(bt, vp, sp0, 10);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        idle(2);
        for (int b = 0; b < 2 * N; b++) bt[b] = $urandom;
        run_tile(bt, vp, sp0, -1);
        chk("post_reset_done", 0, 64'(seen_done), 64'(20));

        // randomized tiles: random valid gaps, junk beats after fill, stray start pulses
        for (int t = 0; t < 25; t++) begin
            for (int b = 0; b < 2 * N; b++) bt[b] = $urandom;
            vp[0] = 1'($urandom_range(1));
            cnt = 0;
            budget = $urandom_range(12);
            for (int r = 1; r < RL; r++) begin
                if (cnt < 2 * N && budget > 0 && $urandom_range(2) == 0) begin
                    vp[r] = 1'b0;
                    budget--;
                end else if (cnt < 2 * N) begin
                    vp[r] = 1'b1;
                    cnt++;
                end else begin
                    vp[r] = 1'($urandom_range(1));
                end
            end
            sp[0] = 1'b0;
            for (int r = 1; r < RL; r++) sp[r] = ($urandom_range(7) == 0);
            run_tile(bt, vp, sp, -1);
            idle($urandom_range(3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vpu_load_seq.md
# vpu_load_seq

Upstream sequencer for the tile loader. Accepts one tile (N A-columns, then N W-rows) over a valid/ready stream and buffers it locally. Replays it as the contiguous load_a/load_w bursts the loader requires, with the bus data aligned to the loader's strobe delay. After a drain, it drives the deload window with per-cycle deload indices and a Johnson phase count, then pulses done.

## Interface
- N, 4: tile dimension; must equal ROW_A = COL_A = ROW_W = COL_W; power of two, ≥2
- BUS_WIDTH, 32: stream/bus beat width; equals N×DATA_WIDTH
- LOAD_LAT, 2: cycles from load strobe to loader's data sample
- DELOAD_LAT, 1: cycles from deload to loader's index sample
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to process a tile; honoured only in IDLE
- s_valid  in  1  stream beat valid
- s_ready  out  1  stream beat ready
- s_data  in  BUS_WIDTH  beat: beats 0..N-1 are A columns, N..2N-1 are W rows
- load_a, load_w  out  1 each  loader write strobes
- a, w  out  BUS_WIDTH each  loader data buses
- deload  out  1  loader read window
- count_deload_a, count_deload_w  out  $clog2(N) each  loader read indices
- johnson_count  out  N  Johnson phase of the deload window
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- stall_cycles  out  16  fill-stall counter (see Configuration)

## Operation
- FSM: IDLE → FILL → BURST → DRAIN → DELOAD → DONE → IDLE.
- IDLE:
  - start=1 → FILL.
  - start in any other state is ignored; no queueing.
- FILL:
  - s_ready=1.
  - Each beat with s_valid&s_ready is written to buffer slot beat_cnt; beat_cnt increments.
  - s_valid gaps stall without penalty.
  - After beat 2N-1 is accepted → BURST; s_ready=0 in that same next cycle.
- BURST: exactly N consecutive cycles with load_a=load_w=1.
  - Burst cycle k issues A slot k on a and W slot N+k on w, each delayed LOAD_LAT cycles through a register pipeline.
  - The loader resets its write counter when the strobe drops, so the run is never broken.
- DRAIN: LOAD_LAT+1 cycles with all strobes 0, so the last loader write lands before reads.
- DELOAD: N cycles with deload=1.
  - DELOAD cycle j drives count_deload_a=count_deload_w=j, delayed DELOAD_LAT cycles.
  - johnson_count advances once per DELOAD cycle: shift left, feeding in the inverted MSB, starting from 0.
- DONE: one cycle; done is registered and pulses coincident with the last index output.
- a, w and count_deload_* are 0 whenever their pipeline slot carries no valid beat or index.
- Reset, asynchronous and valid at any point including mid-burst:
  - State returns to IDLE; all counters, buffer pointers and pipelines clear.
  - Every output is 0.
  - Buffer contents are don't-care.
  - A partially issued burst is abandoned; the loader sees the strobe fall.

## Timing
- Reset value of every output: 0; johnson_count=0.
- start at cycle 0 with s_valid held high:
  - FILL beats accepted in cycles 1..2N.
  - load_a/load_w high in cycles 2N+1..3N.
  - a/w carry beat k at cycle 2N+1+k+LOAD_LAT.
- DRAIN occupies cycles 3N+1..3N+LOAD_LAT+1.
- deload is high for the following N cycles.
- count_deload_* = j appears DELOAD_LAT cycles after DELOAD cycle j.
- done pulses with the last index output, i.e. DELOAD_LAT cycles after the last deload=1 cycle.
- busy falls the cycle after done.
- Total for N=4, LOAD_LAT=2, DELOAD_LAT=1, no stalls: start at cycle 0, done at cycle 20.
- Counter wrap: beat_cnt wraps only by FSM exit; index counters are $clog2(N) bits and naturally wrap N-1→0, which is never issued.

## Configuration
- VPU_LDSEQ_STATS_EN:
  - Defined: stall_cycles counts FILL cycles with s_valid=0.
  - It clears on start, saturates at 16'hFFFF, and holds its value after DONE.
  - Undefined: stall_cycles is tied to 0 and no counter logic exists.

## Test plan
- Reset: reset=0 mid-BURST of a tile → all outputs 0 immediately; after release the FSM is IDLE; a new start processes a fresh tile correctly.
- Basic tile: N=4, beats 0x00000001..0x00000008 continuous → exactly 4 consecutive load_a/load_w cycles.
  - a=0x1..0x4 and w=0x5..0x8, each 2 cycles after its strobe.
  - deload for 4 cycles; indices 0,1,2,3; johnson 0001,0011,0111,1111; done at cycle 20.
- Stalled fill: s_valid deasserted for 3 cycles after beat 2 → bursts still 4 contiguous cycles; done at cycle 23; stall_cycles=3 with VPU_LDSEQ_STATS_EN, 0 without.
- Busy start: start pulsed during FILL and DELOAD → ignored; exactly one done pulse; s_ready=0 outside FILL.
- Back-to-back: start asserted in the cycle after done → second tile processes with identical timing; no residual a/w data between tiles.
